// File: rtl/dacmux_seq_if.sv
// Register-side and analog-side signals of the shared DAC/comparator sequencer.
interface dacmux_seq_if #(
    parameter int NCH = 10
);
    logic [NCH-1:0]   dac_en;
    logic [NCH-1:0]   sar_en;
    logic [NCH-1:0]   wr_vs;
    logic [7:0]       wdat;
    logic             comp_i;
    logic [7:0]       dac_v;
    logic [NCH-1:0]   dac_sel;
    logic             dac_act;
    logic [8*NCH-1:0] vs;
    logic [NCH-1:0]   comp;
    logic             busy;
    logic             scan_done;

    modport master (
        output dac_en, sar_en, wr_vs, wdat, comp_i,
        input  dac_v, dac_sel, dac_act, vs, comp, busy, scan_done
    );

    modport slave (
        input  dac_en, sar_en, wr_vs, wdat, comp_i,
        output dac_v, dac_sel, dac_act, vs, comp, busy, scan_done
    );
endinterface

// File: rtl/dacmux_seq.sv
// Round-robin time-multiplexer of the shared 8-bit DAC and comparator.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | no channel enabled, DAC/mux off
//  S_SEL    | pick next enabled channel, load select and first DAC code
//  S_SETTLE | wait TSET cycles for DAC/comparator to settle
//  S_SAMPLE | capture synchronized comparator; plain: done, SAR: next bit
module dacmux_seq #(
    parameter int         NCH    = 10,
    parameter int         TSET   = 7,
    parameter logic [7:0] RST_VS = 8'h00
) (
    input  logic         clk,
    input  logic         rrstz,
    dacmux_seq_if.slave  bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TSET);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_SETTLE, S_SAMPLE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cur_q, cur_d;
    logic           first_q, first_d;
    logic           sar_q, sar_d;
    logic [2:0]     k_q, k_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic [7:0]     dac_v_q, dac_v_d;
    logic [NCH-1:0] dac_sel_q, dac_sel_d;
    logic           dac_act_q, dac_act_d;
    logic [NCH-1:0] comp_q, comp_d;
    logic [7:0]     vs_q [NCH];
    logic [1:0]     sync_q;

    logic           comp_s;
    logic [7:0]     acc;
    logic           wb_en;
    logic           abort;
    int             base;
    logic           hi_f, lo_f;
    logic [CW-1:0]  hi_ch, lo_ch, pick;

    assign comp_s = sync_q[1];

    // Two-FF synchronizer for the asynchronous comparator.
    always_ff @(posedge clk or negedge rrstz) begin
        if (!rrstz) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], bus.comp_i};
    end

    // Next-channel search: lowest enabled channel at/above base, else lowest below it (wrap).
    always_comb begin
        base  = first_q ? 0 : int'(cur_q) + 1;
        hi_f  = 1'b0;
        lo_f  = 1'b0;
        hi_ch = '0;
        lo_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.dac_en[i]) begin
                if (i >= base) begin
                    hi_f  = 1'b1;
                    hi_ch = CW'(i);
                end else begin
                    lo_f  = 1'b1;
                    lo_ch = CW'(i);
                end
            end
        end
        pick = hi_f ? hi_ch : lo_ch;
    end

    // A wrap (pick at or below the previous channel) or an empty pick ends the scan.
    assign bus.scan_done = (state_q == S_SEL) && !hi_f;

    // Next-state and datapath decode.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        first_d   = first_q;
        sar_d     = sar_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        dac_v_d   = dac_v_q;
        dac_sel_d = dac_sel_q;
        dac_act_d = dac_act_q;
        comp_d    = comp_q;
        wb_en     = 1'b0;
        acc       = dac_v_q;
        acc[k_q]  = comp_s;
        // Channel disabled, or its value register rewritten under a SAR conversion.
        abort     = !bus.dac_en[cur_q] || (sar_q && bus.wr_vs[cur_q]);

        case (state_q)
            S_IDLE: begin
                first_d = 1'b1;
                if (|bus.dac_en) state_d = S_SEL;
            end
            S_SEL: begin
                if (hi_f || lo_f) begin
                    cur_d     = pick;
                    first_d   = 1'b0;
                    dac_sel_d = {{(NCH-1){1'b0}}, 1'b1} << pick;
                    dac_act_d = 1'b1;
                    sar_d     = bus.sar_en[pick];
                    k_d       = 3'd7;
                    cnt_d     = TW'(TSET - 1);
                    dac_v_d   = bus.sar_en[pick] ? 8'h80 : vs_q[pick];
                    state_d   = S_SETTLE;
                end else begin
                    dac_sel_d = '0;
                    dac_act_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_SEL;
                end else if (!sar_q && bus.wr_vs[cur_q]) begin
                    dac_v_d = bus.wdat;
                    cnt_d   = TW'(TSET - 1);
                end else if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_SEL;
                end else begin
                    comp_d[cur_q] = comp_s;
                    if (!sar_q) begin
                        state_d = S_SEL;
                    end else if (k_q != 3'd0) begin
                        dac_v_d = acc | (8'h01 << (k_q - 3'd1));
                        k_d     = k_q - 3'd1;
                        cnt_d   = TW'(TSET - 1);
                        state_d = S_SETTLE;
                    end else begin
                        dac_v_d = acc;
                        wb_en   = 1'b1;
                        state_d = S_SEL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and DAC/mux drive registers.
    always_ff @(posedge clk or negedge rrstz) begin
        if (!rrstz) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            first_q   <= 1'b1;
            sar_q     <= 1'b0;
            k_q       <= 3'd7;
            cnt_q     <= '0;
            dac_v_q   <= 8'h00;
            dac_sel_q <= '0;
            dac_act_q <= 1'b0;
            comp_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            first_q   <= first_d;
            sar_q     <= sar_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            dac_v_q   <= dac_v_d;
            dac_sel_q <= dac_sel_d;
            dac_act_q <= dac_act_d;
            comp_q    <= comp_d;
        end
    end

    // Channel value registers: bus writes take priority over SAR write-back.
    always_ff @(posedge clk or negedge rrstz) begin
        if (!rrstz) begin
            for (int i = 0; i < NCH; i++) vs_q[i] <= RST_VS;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.wr_vs[i])                       vs_q[i] <= bus.wdat;
                else if (wb_en && (cur_q == CW'(i)))   vs_q[i] <= acc;
            end
        end
    end

    // Flatten value registers for readback.
    always_comb begin
        for (int i = 0; i < NCH; i++) bus.vs[8*i +: 8] = vs_q[i];
    end

    assign bus.dac_v   = dac_v_q;
    assign bus.dac_sel = dac_sel_q;
    assign bus.dac_act = dac_act_q;
    assign bus.comp    = comp_q;
    assign bus.busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_dacmux_seq.sv
// Bench for dacmux_seq: directed scenarios plus randomized scans against a visit-level model.
module tb_dacmux_seq;
    localparam int         NCH    = 10;
    localparam int         TSET   = 3;
    localparam logic [7:0] RST_VS = 8'h5A;

    logic clk = 1'b0;
    logic rrstz = 1'b0;

    dacmux_seq_if #(.NCH(NCH)) bus ();

    dacmux_seq #(.NCH(NCH), .TSET(TSET), .RST_VS(RST_VS)) dut (
        .clk   (clk),
        .rrstz (rrstz),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Analog model: each channel has an input level; comparator is 1 when level >= DAC code.
    logic [7:0] ana [NCH];
    logic [7:0] sel_ana;
    always_comb begin
        sel_ana = 8'h00;
        for (int i = 0; i < NCH; i++) if (bus.dac_sel[i]) sel_ana = ana[i];
    end
    assign bus.comp_i = bus.dac_act && (sel_ana >= bus.dac_v);

    logic [7:0]     exp_vs [NCH];
    logic [NCH-1:0] exp_comp;
    int             m_cur;
    bit             m_first;
    int             ncmp = 0;
    int             nfail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8*NCH-1:0] vs_vec();
        logic [8*NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[8*i +: 8] = exp_vs[i];
        return v;
    endfunction

    // SAR trial code after j decided bits: known top bits of the level, then the trial bit.
    function automatic logic [7:0] trial(input logic [7:0] a, input int j);
        logic [7:0] keep;
        logic [7:0] tb_bit;
        keep   = 8'hFF >> j;
        tb_bit = 8'h80 >> j;
        return (a & ~keep) | tb_bit;
    endfunction

    function automatic int next_ch(input logic [NCH-1:0] en);
        int start;
        int c;
        start = m_first ? 0 : m_cur + 1;
        for (int i = 0; i < NCH; i++) begin
            c = (start + i) % NCH;
            if (en[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        logic [8*NCH-1:0] rv;
        rrstz = 1'b0;
        #2;
        for (int i = 0; i < NCH; i++) rv[8*i +: 8] = RST_VS;
        chk("rst_dac_v", bus.dac_v, 0);
        chk("rst_dac_sel", bus.dac_sel, 0);
        chk("rst_dac_act", bus.dac_act, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_scan_done", bus.scan_done, 0);
        chk("rst_comp", bus.comp, 0);
        chk("rst_vs", bus.vs, rv);
        rrstz = 1'b1;
        for (int i = 0; i < NCH; i++) exp_vs[i] = RST_VS;
        exp_comp = '0;
        m_first  = 1'b1;
        m_cur    = 0;
    endtask

    task automatic wr(input logic [NCH-1:0] mask, input logic [7:0] data);
        bus.wr_vs = mask;
        bus.wdat  = data;
        tick();
        bus.wr_vs = '0;
        for (int i = 0; i < NCH; i++) if (mask[i]) exp_vs[i] = data;
    endtask

    // Called at the start of a SEL cycle; checks n whole channel visits.
    task automatic run_visits(input int n);
        int ch;
        for (int v = 0; v < n; v++) begin
            ch = next_ch(bus.dac_en);
            if (!m_first) chk("scan_done", bus.scan_done, (ch <= m_cur));
            chk("busy_sel", bus.busy, 1);
            tick();
            chk("dac_sel", bus.dac_sel, 1 << ch);
            chk("dac_act", bus.dac_act, 1);
            if (bus.sar_en[ch]) begin
                for (int j = 0; j < 8; j++) begin
                    chk("sar_trial", bus.dac_v, trial(ana[ch], j));
                    repeat (TSET + 1) tick();
                end
                exp_vs[ch]   = ana[ch];
                exp_comp[ch] = ana[ch][0];
            end else begin
                chk("plain_dac_v", bus.dac_v, exp_vs[ch]);
                repeat (TSET + 1) tick();
                exp_comp[ch] = (ana[ch] >= exp_vs[ch]);
            end
            chk("vs_after_visit", bus.vs, vs_vec());
            chk("comp_after_visit", bus.comp, exp_comp);
            m_cur   = ch;
            m_first = 1'b0;
        end
    endtask

    task automatic stop_seq();
        bus.dac_en = '0;
        tick();
        chk("stop_busy", bus.busy, 0);
        chk("stop_dac_act", bus.dac_act, 0);
        chk("stop_dac_sel", bus.dac_sel, 0);
        m_first = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.dac_en = '0;
        bus.sar_en = '0;
        bus.wr_vs  = '0;
        bus.wdat   = 8'h00;
        for (int i = 0; i < NCH; i++) ana[i] = 8'h00;
        tick();
        do_reset();

        // 1: single plain channel, revisited back-to-back
        wr(10'h004, 8'h40);
        ana[2]     = 8'hFF;
        bus.dac_en = 10'h004;
        tick();
        run_visits(3);
        stop_seq();

        // 2: single SAR channel converging on A5
        do_reset();
        ana[5]     = 8'hA5;
        bus.dac_en = 10'h020;
        bus.sar_en = 10'h020;
        tick();
        run_visits(2);
        chk("sar_a5", bus.vs[8*5 +: 8], 8'hA5);
        stop_seq();

        // 3: plain channels 0,2,9 in round-robin order
        bus.sar_en = '0;
        for (int i = 0; i < NCH; i++) ana[i] = 8'($urandom);
        bus.dac_en = 10'b1000000101;
        tick();
        run_visits(5);
        stop_seq();

        // Multiple write strobes in one cycle
        wr(10'b0011000011, 8'($urandom));
        chk("multi_wr", bus.vs, vs_vec());

        // 4: write to the converting SAR channel aborts its conversion
        do_reset();
        ana[5]     = 8'($urandom);
        ana[7]     = 8'($urandom);
        bus.dac_en = 10'h0A0;
        bus.sar_en = 10'h020;
        tick();
        tick();
        repeat (4 * (TSET + 1)) tick();
        chk("abort_trial", bus.dac_v, trial(ana[5], 4));
        bus.wr_vs = 10'h020;
        bus.wdat  = 8'h3C;
        tick();
        bus.wr_vs = '0;
        exp_vs[5] = 8'h3C;
        chk("abort_vs5", bus.vs[8*5 +: 8], 8'h3C);
        chk("abort_busy", bus.busy, 1);
        chk("abort_scan_done", bus.scan_done, 0);
        tick();
        chk("abort_next_sel", bus.dac_sel, 10'h080);
        bus.dac_en = 10'h080;
        repeat (TSET + 1) tick();
        exp_comp[5] = (ana[5] >= trial(ana[5], 3));
        exp_comp[7] = (ana[7] >= exp_vs[7]);
        m_cur   = 7;
        m_first = 1'b0;
        run_visits(2);
        stop_seq();

        // 5: enable dropped mid-settle
        do_reset();
        ana[3]     = 8'hFF;
        bus.sar_en = '0;
        bus.dac_en = 10'h008;
        tick();
        tick();
        bus.dac_en = '0;
        tick();
        chk("drop_busy_sel", bus.busy, 1);
        tick();
        chk("drop_busy", bus.busy, 0);
        chk("drop_dac_act", bus.dac_act, 0);
        chk("drop_dac_sel", bus.dac_sel, 0);
        chk("drop_comp", bus.comp, exp_comp);
        repeat (4) tick();
        chk("drop_vs", bus.vs, vs_vec());
        chk("drop_idle", bus.busy, 0);

        // 6: reset during a SAR conversion, rescan from ch0
        ana[0]     = 8'($urandom);
        ana[5]     = 8'($urandom);
        bus.sar_en = 10'h020;
        bus.dac_en = 10'h020;
        tick();
        repeat (10) tick();
        bus.dac_en = 10'h021;
        do_reset();
        tick();
        run_visits(2);
        stop_seq();

        // Randomized scans
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < NCH; i++) begin
                ana[i] = 8'($urandom);
                if ($urandom_range(0, 1) == 1) wr(NCH'(1) << i, 8'($urandom));
            end
            bus.sar_en = NCH'($urandom_range(0, (1 << NCH) - 1));
            bus.dac_en = NCH'($urandom_range(1, (1 << NCH) - 1));
            tick();
            run_visits($countones(bus.dac_en) * 2 + 1);
            stop_seq();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
